mux_rr_arbiter: RTL and testbench
=================================

// Module: mux_rr_arbiter
// PURPOSE
//   Shares one N:1 select datapath among N requesters using fair round-robin
//   arbitration with valid/ready handshakes on both sides.
//   Each accepted request is captured into an output register and presented
//   downstream, together with the index of the winning source.
//   Sits in front of the 4:1 select mux. It generates the select code and owns
//   the mux result register.
// PARAMETERS
//   N   4   number of requesters; N >= 2
//   W   8   data width per requester
//   SW  $clog2(N)   select/index width; derived, not overridden
// PORTS
//   clk        in   1     single clock, rising edge
//   rst        in   1     asynchronous, active-high reset
//   req_valid  in   N     requester i has data on its slice of req_data
//   req_data   in   N*W   requester i data at [i*W +: W]
//   req_ready  out  N     one-hot; requester i is accepted this cycle
//   out_valid  out  1     out_data / out_src hold a captured request
//   out_data   out  W     captured data of the winner
//   out_src    out  SW    index of the winner (the mux select code)
//   out_ready  in   1     downstream accepts out_data this cycle
// BEHAVIOUR
//   Reset (async assert, sync release):
//     state=IDLE, ptr=0, out_valid=0, out_data=0, out_src=0.
//     req_ready=0 while rst is high.
//   FSM states:
//     IDLE: no captured data.
//     HOLD: out_valid=1, waiting for out_ready.
//   IDLE:
//     winner = first i with req_valid[i]=1, scanning ptr, ptr+1, ... mod N.
//     req_ready = one-hot(winner), combinational, only when any req_valid=1.
//     At the clock edge: out_data <= req_data[winner]; out_src <= winner;
//     ptr <= (winner+1) mod N; state <= HOLD.
//     With no request: req_ready=0, all state is held.
//   HOLD:
//     req_ready=0. out_data and out_src are stable.
//     On out_ready=1: state <= IDLE, out_valid <= 0.
//   Latency and throughput:
//     Request accepted in cycle T; out_valid=1 from T+1.
//     Minimum spacing between grants is 2 cycles (no IDLE->HOLD bypass).
//   Handshake rules:
//     A requester transfers only in a cycle where both req_valid[i] and
//     req_ready[i] are high.
//     Requesters keep req_valid and data stable until accepted. The arbiter
//     does not rely on this, because data is sampled only in the accept cycle.
//   Fairness:
//     A requester that holds req_valid high is granted within N grants.
//     ptr moves only on a grant.
//   Wrap-around: ptr=N-1 and winner=N-1 -> ptr becomes 0.
//   Simultaneous requests: all N valid with ptr=k -> grant order is
//     k, k+1, ..., k-1.
//   Request dropped in IDLE: a requester that deasserts before acceptance is
//     skipped, and no state changes for it.
//   out_ready=1 in IDLE is ignored.
//   Reset mid-operation: a captured but unconsumed item is discarded.
//     out_valid clears immediately on rst, not at the next edge.
// STRUCTURE
//   Shared package mux_pkg:
//     - state encoding localparams ST_IDLE=1'b0, ST_HOLD=1'b1
//     - default N and W constants
//   Sub-module rr_pick (combinational):
//     - inputs: req[N-1:0], ptr[SW-1:0]
//     - outputs: gnt[N-1:0] one-hot, idx[SW-1:0], any
//     - implemented as a double-width rotate-and-priority scan
//   Top level: FSM, ptr register, output registers, and the req_data slice mux
//     indexed by idx.
// TESTING
//   1 Reset: rst high mid-HOLD with out_valid=1 -> out_valid=0, out_src=0,
//     req_ready=0 at once; after release, next grant starts from index 0.
//   2 Single requester: req_valid=4'b0100, data[2]=8'hA5 -> req_ready=4'b0100
//     in T; at T+1 out_valid=1, out_data=8'hA5, out_src=2; ptr=3.
//   3 All four valid, out_ready tied 1, data[i]=8'h10+i -> out_src sequence
//     0,1,2,3,0 with out_valid on every 2nd cycle.
//   4 Backpressure: out_ready=0 for 5 cycles in HOLD -> out_data and out_src
//     unchanged, req_ready=0 throughout; out_ready=1 -> IDLE next cycle.
//   5 Wrap and skip: ptr=3, req_valid=4'b0011 -> grant 0, then grant 1, then
//     grant 0 again (ptr wrap from 3 to 0 verified).
//   6 Fairness: req 0 always valid, req 3 raised at a random cycle -> req 3
//     granted within 4 grants; no grant ever without req_valid.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and state encoding for the round-robin select-mux arbiter.
package mux_pkg;

  localparam int MUX_N = 4;
  localparam int MUX_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester-side and downstream-side handshake bundle of the round-robin arbiter.
interface mux_rr_arbiter_if
  import mux_pkg::*;
#(
  parameter int N = MUX_N,
  parameter int W = MUX_W
);
  localparam int SW = $clog2(N);

  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;
  logic           out_ready;

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_src
  );

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [SW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [SW-1:0] idx_o,
  output logic          any_o
);

  logic [2*N-1:0] dbl;
  logic           found;

  // Scanning ptr..ptr+N-1 of the doubled vector gives the wrap for free.
  always_comb begin
    dbl   = {req_i, req_i};
    found = 1'b0;
    idx_o = '0;
    for (int j = 0; j < N; j++) begin
      if (!found && dbl[int'(ptr_i) + j]) begin
        found = 1'b1;
        idx_o = SW'((int'(ptr_i) + j) % N);
      end
    end
    any_o = |req_i;
    gnt_o = any_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the N:1 select code and the captured-result register.
//
// state   | meaning
// ST_IDLE | no captured data; winner of rr_pick is accepted at the edge
// ST_HOLD | out_valid=1, result held until out_ready
module mux_rr_arbiter
  import mux_pkg::*;
#(
  parameter int N = MUX_N,
  parameter int W = MUX_W
) (
  input logic             clk,
  input logic             rst,
  mux_rr_arbiter_if.slave bus
);

  localparam int SW = $clog2(N);

  state_e        state_q;
  logic [SW-1:0] ptr_q;
  logic [SW-1:0] ptr_d;
  logic          out_valid_q;
  logic [W-1:0]  out_data_q;
  logic [SW-1:0] out_src_q;

  logic [N-1:0]  gnt;
  logic [SW-1:0] idx;
  logic          any;
  logic [W-1:0]  sel_data;

  rr_pick #(.N(N), .SW(SW)) u_pick (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (idx),
    .any_o (any)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == SW'(i)) sel_data = bus.req_data[i*W +: W];
    end
  end

  assign ptr_d = (idx == SW'(N - 1)) ? '0 : idx + SW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any) begin
            out_data_q  <= sel_data;
            out_src_q   <= idx;
            ptr_q       <= ptr_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Grants are suppressed while reset is asserted, not just after the next edge.
  assign bus.req_ready = (state_q == ST_IDLE && !rst) ? gnt : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed and randomized checks of mux_rr_arbiter against a behavioural round-robin model.
module tb_mux_rr_arbiter;
  import mux_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mux_rr_arbiter_if #(.N(N), .W(W)) bus ();

  mux_rr_arbiter #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: holding flag, rotating pointer, captured item.
  bit           m_hold;
  int           m_ptr;
  int           m_src;
  logic [W-1:0] m_data;
  int           last_win;

  task automatic model_reset();
    m_hold = 1'b0;
    m_ptr  = 0;
    m_src  = 0;
    m_data = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_winner();
    if (m_hold) return -1;
    for (int k = 0; k < N; k++) begin
      if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // Inputs are set by the caller; compare mid-cycle, then advance one clock.
  task automatic cyc(input string tag);
    int           w;
    logic [N-1:0] one;
    logic [N-1:0] er;
    one = 1;
    #1;
    w  = model_winner();
    er = (w >= 0) ? (one << w) : '0;
    chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'(er));
    chk({tag, ".no_gnt_wo_valid"}, 32'(bus.req_ready & ~bus.req_valid), 32'd0);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_hold));
    chk({tag, ".out_data"}, 32'(bus.out_data), 32'(m_data));
    chk({tag, ".out_src"}, 32'(bus.out_src), 32'(m_src));
    last_win = -1;
    @(posedge clk);
    if (w >= 0) begin
      m_data   = bus.req_data[w*W +: W];
      m_src    = w;
      m_ptr    = (w + 1) % N;
      m_hold   = 1'b1;
      last_win = w;
    end else if (m_hold && bus.out_ready) begin
      m_hold = 1'b0;
    end
    #1;
  endtask

  initial begin
    int           seq[$];
    int           exp_seq[5];
    int           r;
    int           g;
    bit           done;
    logic [N-1:0] v;

    exp_seq = '{0, 1, 2, 3, 0};
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    model_reset();
    last_win = -1;

    // Reset: outputs cleared and no grant while rst is high, even with requests.
    #1 rst = 1'b1;
    bus.req_valid = 4'hF;
    #1;
    chk("rst.req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.out_src", 32'(bus.out_src), 32'd0);
    chk("rst.out_data", 32'(bus.out_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // All four valid, out_ready tied high: grants 0,1,2,3,0 every 2nd cycle.
    bus.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req_valid = 4'hF;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cyc("all4");
      if (last_win >= 0) seq.push_back(last_win);
    end
    chk("all4.count", 32'(seq.size()), 32'd5);
    for (int i = 0; i < 5 && i < seq.size(); i++) chk("all4.order", 32'(seq[i]), 32'(exp_seq[i]));

    // Single requester 2 with A5.
    bus.req_valid = 4'b0100;
    bus.req_data  = 32'h00A5_0000;
    bus.out_ready = 1'b0;
    #1;
    chk("single.req_ready", 32'(bus.req_ready), 32'h4);
    cyc("single");
    chk("single.out_valid", 32'(bus.out_valid), 32'd1);
    chk("single.out_data", 32'(bus.out_data), 32'hA5);
    chk("single.out_src", 32'(bus.out_src), 32'd2);

    // Backpressure: held for 5 cycles while other requests and data churn.
    bus.req_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      bus.req_data = $urandom;
      cyc("bp");
      chk("bp.out_data", 32'(bus.out_data), 32'hA5);
      chk("bp.out_src", 32'(bus.out_src), 32'd2);
      chk("bp.req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b0011;
    bus.req_data  = 32'h0000_2211;
    cyc("bp_release");
    chk("bp_release.out_valid", 32'(bus.out_valid), 32'd0);

    // Wrap and skip: ptr is 3, only 0 and 1 request -> 0, 1, 0.
    seq.delete();
    for (int c = 0; c < 6; c++) begin
      cyc("wrap");
      if (last_win >= 0) seq.push_back(last_win);
    end
    chk("wrap.count", 32'(seq.size()), 32'd3);
    if (seq.size() == 3) begin
      chk("wrap.g0", 32'(seq[0]), 32'd0);
      chk("wrap.g1", 32'(seq[1]), 32'd1);
      chk("wrap.g2", 32'(seq[2]), 32'd0);
    end

    // Reset mid-HOLD discards the item at once; next grant starts at 0.
    bus.req_valid = 4'hF;
    bus.req_data  = 32'h4433_2211;
    bus.out_ready = 1'b0;
    cyc("pre_rst");
    chk("pre_rst.out_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst.out_src", 32'(bus.out_src), 32'd0);
    chk("midrst.req_ready", 32'(bus.req_ready), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("post_rst");
    chk("post_rst.winner", 32'(last_win), 32'd0);

    // Fairness: req 0 always on, req 3 raised at a random cycle and held.
    for (int t = 0; t < 20; t++) begin
      r    = $urandom_range(0, 7);
      g    = 0;
      done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
        v    = 4'(($urandom & 32'h6) | 32'h1);
        v[3] = (c >= r);
        bus.req_valid = v;
        bus.req_data  = $urandom;
        bus.out_ready = 1'($urandom_range(0, 1));
        cyc("fair");
        if (c >= r && last_win >= 0) begin
          g++;
          if (last_win == 3) done = 1'b1;
        end
      end
      chk("fair.granted", 32'(done), 32'd1);
      chk("fair.within_n", 32'(g <= N), 32'd1);
    end

    // Fully random traffic against the model.
    for (int c = 0; c < 300; c++) begin
      bus.req_valid = 4'($urandom);
      bus.req_data  = $urandom;
      bus.out_ready = 1'($urandom_range(0, 1));
      cyc("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
